spsram_param: RTL and testbench

- Parametrised single-port synchronous SRAM; successor to the fixed 32x32 doubled SRAM.
- Adds generic data width and depth, per-byte write enables, and a selectable 1- or 2-cycle registered read latency with a valid flag.
- Adds a hardware clear engine that fills the array with INIT_VAL after reset or on request.
- Used as the scratch and buffer memory behind datapath blocks in the lab SoC.

---
 rtl/spsram_pkg.sv | 20 ++
 rtl/spsram_param_if.sv | 27 ++
 rtl/spsram_clr_ctrl.sv | 66 ++++++
 rtl/spsram_param.sv | 111 +++++++++++
 tb/tb_spsram_param.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/spsram_pkg.sv
// Shared types and elaboration helpers for the parametrised single-port SRAM.
// The clear controller and the top level both import this package.
package spsram_pkg;

   typedef enum logic [0:0] {
      ST_CLEAR = 1'b0,
      ST_RUN   = 1'b1
   } state_t;

   localparam int RD_LAT_MIN = 1;
   localparam int RD_LAT_MAX = 2;

   // True when the width is whole bytes, the array fits the address space
   // and the read latency is one of the supported values.
   function automatic bit cfg_ok(input int dw, input int aw, input int depth, input int rd_lat);
      return (dw > 0) && (dw % 8 == 0) && (depth > 0) && (depth <= (1 << aw)) &&
             (rd_lat >= RD_LAT_MIN) && (rd_lat <= RD_LAT_MAX);
   endfunction

endpackage

// File: rtl/spsram_param_if.sv
// Access bus of the parametrised SRAM: request fields driven by the master,
// read result, valid pulse and busy flag returned by the slave.
interface spsram_param_if #(
   parameter int DW = 32,
   parameter int AW = 5
);
   logic            i_cen;
   logic            i_wen;
   logic            i_oen;
   logic [DW/8-1:0] i_be;
   logic [AW-1:0]   i_addr;
   logic [DW-1:0]   i_data;
   logic            i_clr;
   logic [DW-1:0]   o_data;
   logic            o_valid;
   logic            o_busy;

   modport master (
      output i_cen, i_wen, i_oen, i_be, i_addr, i_data, i_clr,
      input  o_data, o_valid, o_busy
   );

   modport slave (
      input  i_cen, i_wen, i_oen, i_be, i_addr, i_data, i_clr,
      output o_data, o_valid, o_busy
   );
endinterface

// File: rtl/spsram_clr_ctrl.sv
// Clear engine: walks the array once writing the init value, either after
// reset or on request, and holds the busy flag for exactly DEPTH cycles.
module spsram_clr_ctrl
   import spsram_pkg::*;
#(
   parameter int AW         = 5,
   parameter int DEPTH      = 32,
   parameter int CLR_ON_RST = 1
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_clr,
   output logic [AW-1:0] clr_addr,
   output logic          clr_we,
   output logic          o_busy
);

   localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

   state_t        state;
   logic [AW-1:0] cnt;
   logic          busy_q;

   // A clear request while already sweeping is ignored; only reset restarts a sweep.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         cnt <= '0;
         if (CLR_ON_RST != 0) begin
            state  <= ST_CLEAR;
            busy_q <= 1'b1;
         end else begin
            state  <= ST_RUN;
            busy_q <= 1'b0;
         end
      end else begin
         case (state)
            ST_CLEAR: begin
               if (cnt == LAST_ADDR) begin
                  state  <= ST_RUN;
                  busy_q <= 1'b0;
                  cnt    <= '0;
               end else begin
                  cnt <= cnt + AW'(1);
               end
            end
            ST_RUN: begin
               if (i_clr) begin
                  state  <= ST_CLEAR;
                  busy_q <= 1'b1;
                  cnt    <= '0;
               end
            end
            default: begin
               state  <= ST_RUN;
               busy_q <= 1'b0;
               cnt    <= '0;
            end
         endcase
      end
   end

   assign clr_addr = cnt;
   assign clr_we   = busy_q;
   assign o_busy   = busy_q;

endmodule

// File: rtl/spsram_param.sv
// Parametrised single-port synchronous SRAM with byte enables, a registered
// read pipeline of RD_LAT stages and a hardware clear engine.
module spsram_param
   import spsram_pkg::*;
#(
   parameter int            DW         = 32,
   parameter int            AW         = 5,
   parameter int            DEPTH      = 32,
   parameter int            RD_LAT     = 1,
   parameter int            CLR_ON_RST = 1,
   parameter logic [DW-1:0] INIT_VAL   = '0
) (
   input logic           i_clk,
   input logic           i_rst,
   spsram_param_if.slave bus
);

   localparam int NB = DW / 8;

   if (!cfg_ok(DW, AW, DEPTH, RD_LAT)) begin : g_cfg_err
      $error("spsram_param: illegal DW/AW/DEPTH/RD_LAT combination");
   end

   logic [DW-1:0] mem [DEPTH];

   logic [AW-1:0] clr_addr;
   logic          clr_we;
   logic          busy;

   spsram_clr_ctrl #(
      .AW        (AW),
      .DEPTH     (DEPTH),
      .CLR_ON_RST(CLR_ON_RST)
   ) u_clr_ctrl (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_clr   (bus.i_clr),
      .clr_addr(clr_addr),
      .clr_we  (clr_we),
      .o_busy  (busy)
   );

   logic          acc_ok;
   logic          in_range;
   logic          wr_req;
   logic          rd_req;
   logic [DW-1:0] cur_word;
   logic [DW-1:0] merged;

   // A clear request in the same cycle wins over the access; out-of-range
   // addresses read as zero and never reach the array.
   always_comb begin
      acc_ok   = ~busy & ~bus.i_clr & bus.i_cen;
      in_range = ({1'b0, bus.i_addr} < (AW + 1)'(DEPTH));
      wr_req   = acc_ok & bus.i_wen & in_range;
      rd_req   = acc_ok & ~bus.i_wen & bus.i_oen;
      cur_word = in_range ? mem[bus.i_addr] : '0;
      merged   = cur_word;
      for (int k = 0; k < NB; k++) begin
         if (bus.i_be[k]) begin
            merged[8*k +: 8] = bus.i_data[8*k +: 8];
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         if (clr_we) begin
            mem[clr_addr] <= INIT_VAL;
         end else if (wr_req) begin
            mem[bus.i_addr] <= merged;
         end
      end
   end

   logic [DW-1:0]     pipe_data [RD_LAT];
   logic [RD_LAT-1:0] pipe_vld;
   logic [DW-1:0]     data_q;
   logic              valid_q;

   // Reads in flight keep advancing during a clear sweep, so they return the
   // data captured when they were accepted.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         pipe_vld <= '0;
         for (int i = 0; i < RD_LAT; i++) begin
            pipe_data[i] <= '0;
         end
         data_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         pipe_vld[0] <= rd_req;
         if (rd_req) begin
            pipe_data[0] <= cur_word;
         end
         for (int i = 1; i < RD_LAT; i++) begin
            pipe_vld[i]  <= pipe_vld[i-1];
            pipe_data[i] <= pipe_data[i-1];
         end
         valid_q <= pipe_vld[RD_LAT-1];
         if (pipe_vld[RD_LAT-1]) begin
            data_q <= pipe_data[RD_LAT-1];
         end
      end
   end

   assign bus.o_data  = data_q;
   assign bus.o_valid = valid_q;
   assign bus.o_busy  = busy;

endmodule

// File: tb/tb_spsram_param.sv
// Scoreboard bench driving two SRAM configurations in lockstep: a full 32-word
// array with 1-cycle reads and a 24-word array with 2-cycle reads.
module tb_spsram_param;

   localparam int          DEPTH_A = 32;
   localparam int          LAT_A   = 1;
   localparam logic [31:0] INIT_A  = 32'hDEADBEEF;
   localparam int          DEPTH_B = 24;
   localparam int          LAT_B   = 2;
   localparam logic [31:0] INIT_B  = 32'h0F0F0F0F;

   typedef struct {
      logic [31:0] data;
      int          due;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   tests = 0;
   int   failures = 0;
   bit   tb_busy = 1'b1;

   logic [31:0] model_a [32];
   logic [31:0] model_b [32];
   exp_t        q_a [$];
   exp_t        q_b [$];
   exp_t        e_a;
   exp_t        e_b;

   spsram_param_if #(.DW(32), .AW(5)) bus_a ();
   spsram_param_if #(.DW(32), .AW(5)) bus_b ();

   spsram_param #(
      .DW(32), .AW(5), .DEPTH(DEPTH_A), .RD_LAT(LAT_A), .CLR_ON_RST(1), .INIT_VAL(INIT_A)
   ) dut_a (
      .i_clk(clk),
      .i_rst(rst),
      .bus  (bus_a.slave)
   );

   spsram_param #(
      .DW(32), .AW(5), .DEPTH(DEPTH_B), .RD_LAT(LAT_B), .CLR_ON_RST(1), .INIT_VAL(INIT_B)
   ) dut_b (
      .i_clk(clk),
      .i_rst(rst),
      .bus  (bus_b.slave)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [31:0] mergeBytes(input logic [31:0] old, input logic [31:0] nw,
                                              input logic [3:0] be);
      logic [31:0] r;
      r = old;
      for (int k = 0; k < 4; k++) begin
         if (be[k]) r[8*k +: 8] = nw[8*k +: 8];
      end
      return r;
   endfunction

   task automatic setInputs(input logic cen, input logic wen, input logic oen, input logic [3:0] be,
                            input logic [4:0] addr, input logic [31:0] data, input logic clr);
      bus_a.i_cen = cen;  bus_b.i_cen = cen;
      bus_a.i_wen = wen;  bus_b.i_wen = wen;
      bus_a.i_oen = oen;  bus_b.i_oen = oen;
      bus_a.i_be = be;    bus_b.i_be = be;
      bus_a.i_addr = addr; bus_b.i_addr = addr;
      bus_a.i_data = data; bus_b.i_data = data;
      bus_a.i_clr = clr;  bus_b.i_clr = clr;
   endtask

   // Drive one cycle of stimulus and record what each array must do with it.
   task automatic applyStimulus(input logic cen, input logic wen, input logic oen, input logic [3:0] be,
                                input logic [4:0] addr, input logic [31:0] data, input logic clr);
      setInputs(cen, wen, oen, be, addr, data, clr);
      if (!tb_busy && !clr && cen) begin
         if (wen) begin
            if (int'(addr) < DEPTH_A) model_a[addr] = mergeBytes(model_a[addr], data, be);
            if (int'(addr) < DEPTH_B) model_b[addr] = mergeBytes(model_b[addr], data, be);
         end else if (oen) begin
            q_a.push_back('{data: (int'(addr) < DEPTH_A) ? model_a[addr] : 32'h0, due: cyc + 1 + LAT_A});
            q_b.push_back('{data: (int'(addr) < DEPTH_B) ? model_b[addr] : 32'h0, due: cyc + 1 + LAT_B});
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) applyStimulus(1'b0, 1'b0, 1'b0, 4'h0, 5'd0, 32'h0, 1'b0);
   endtask

   task automatic readAll();
      for (int a = 0; a < 32; a++) applyStimulus(1'b1, 1'b0, 1'b1, 4'hF, 5'(a), 32'h0, 1'b0);
   endtask

   // Count busy cycles over a bounded window; the current inputs stay applied
   // for the first 'hold' cycles so they land while the arrays are clearing.
   task automatic countBusy(input int window, input int hold, output int na, output int nb);
      na = 0;
      nb = 0;
      for (int i = 0; i < window; i++) begin
         @(negedge clk);
         if (bus_a.o_busy === 1'b1) na++;
         if (bus_b.o_busy === 1'b1) nb++;
         if (i == hold - 1) setInputs(1'b0, 1'b0, 1'b0, 4'h0, 5'd0, 32'h0, 1'b0);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic resetModels();
      for (int a = 0; a < 32; a++) begin
         model_a[a] = INIT_A;
         model_b[a] = (a < DEPTH_B) ? INIT_B : 32'h0;
      end
   endtask

   always @(negedge clk) begin
      if (bus_a.o_valid === 1'b1) begin
         if (q_a.size() == 0) begin
            checkOutput("A spurious valid", 32'd1, 32'd0);
         end else begin
            e_a = q_a.pop_front();
            checkOutput("A rdata", bus_a.o_data, e_a.data);
            checkOutput("A latency", cyc, e_a.due);
         end
      end else if (q_a.size() > 0 && q_a[0].due <= cyc) begin
         void'(q_a.pop_front());
         checkOutput("A missing valid", 32'd0, 32'd1);
      end
   end

   always @(negedge clk) begin
      if (bus_b.o_valid === 1'b1) begin
         if (q_b.size() == 0) begin
            checkOutput("B spurious valid", 32'd1, 32'd0);
         end else begin
            e_b = q_b.pop_front();
            checkOutput("B rdata", bus_b.o_data, e_b.data);
            checkOutput("B latency", cyc, e_b.due);
         end
      end else if (q_b.size() > 0 && q_b[0].due <= cyc) begin
         void'(q_b.pop_front());
         checkOutput("B missing valid", 32'd0, 32'd1);
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, got %0d cycles expected fewer", cyc);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int na;
      int nb;

      setInputs(1'b0, 1'b0, 1'b0, 4'h0, 5'd0, 32'h0, 1'b0);
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checkOutput("A rst data", bus_a.o_data, 32'h0);
      checkOutput("A rst valid", 32'(bus_a.o_valid), 32'd0);
      checkOutput("A rst busy", 32'(bus_a.o_busy), 32'd1);
      checkOutput("B rst data", bus_b.o_data, 32'h0);
      checkOutput("B rst valid", 32'(bus_b.o_valid), 32'd0);
      checkOutput("B rst busy", 32'(bus_b.o_busy), 32'd1);
      @(posedge clk);
      #1;
      rst = 1'b0;
      resetModels();

      // Sweep after reset, with a read held during the first cycles of it.
      setInputs(1'b1, 1'b0, 1'b1, 4'hF, 5'd2, 32'h0, 1'b0);
      countBusy(40, 3, na, nb);
      checkOutput("A busy after reset", 32'(na), 32'(DEPTH_A));
      checkOutput("B busy after reset", 32'(nb), 32'(DEPTH_B));
      tb_busy = 1'b0;

      $display("[TB] read back init values");
      readAll();
      idle(4);

      $display("[TB] write data=addr, read back-to-back");
      for (int a = 0; a < 32; a++) applyStimulus(1'b1, 1'b1, 1'b0, 4'hF, 5'(a), 32'(a), 1'b0);
      readAll();
      idle(4);

      $display("[TB] byte enables and no-op accesses");
      applyStimulus(1'b1, 1'b1, 1'b1, 4'b1111, 5'd7, 32'hAABBCCDD, 1'b0);
      applyStimulus(1'b1, 1'b1, 1'b0, 4'b0101, 5'd7, 32'h11223344, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b1, 4'hF, 5'd7, 32'h0, 1'b0);
      applyStimulus(1'b1, 1'b1, 1'b0, 4'b0000, 5'd9, 32'hFFFFFFFF, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0, 4'hF, 5'd9, 32'h0, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b1, 4'hF, 5'd9, 32'h0, 1'b0);
      idle(4);
      checkOutput("byte merge model", model_a[7], 32'hAA22CC44);

      $display("[TB] out-of-range write and full readback");
      applyStimulus(1'b1, 1'b1, 1'b0, 4'hF, 5'd30, 32'h55, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b1, 4'hF, 5'd30, 32'h0, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b1, 4'hF, 5'd23, 32'h0, 1'b0);
      readAll();
      idle(4);

      $display("[TB] read then clear request");
      applyStimulus(1'b1, 1'b0, 1'b1, 4'hF, 5'd3, 32'h0, 1'b0);
      tb_busy = 1'b1;
      applyStimulus(1'b1, 1'b0, 1'b1, 4'hF, 5'd4, 32'h0, 1'b1);
      setInputs(1'b1, 1'b0, 1'b1, 4'hF, 5'd5, 32'h0, 1'b1);
      countBusy(40, 3, na, nb);
      checkOutput("A busy after clr", 32'(na), 32'(DEPTH_A));
      checkOutput("B busy after clr", 32'(nb), 32'(DEPTH_B));
      tb_busy = 1'b0;
      resetModels();
      applyStimulus(1'b1, 1'b0, 1'b1, 4'hF, 5'd3, 32'h0, 1'b0);
      applyStimulus(1'b1, 1'b1, 1'b0, 4'hF, 5'd3, 32'h00001234, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b1, 4'hF, 5'd3, 32'h0, 1'b0);
      idle(5);

      $display("[TB] reset in the middle of a sweep");
      tb_busy = 1'b1;
      applyStimulus(1'b0, 1'b0, 1'b0, 4'h0, 5'd0, 32'h0, 1'b1);
      idle(9);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      checkOutput("A midrst data", bus_a.o_data, 32'h0);
      checkOutput("A midrst valid", 32'(bus_a.o_valid), 32'd0);
      checkOutput("B midrst data", bus_b.o_data, 32'h0);
      checkOutput("B midrst valid", 32'(bus_b.o_valid), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      countBusy(40, 0, na, nb);
      checkOutput("A busy after midrst", 32'(na), 32'(DEPTH_A));
      checkOutput("B busy after midrst", 32'(nb), 32'(DEPTH_B));
      tb_busy = 1'b0;
      resetModels();
      readAll();
      idle(6);

      checkOutput("A queue drained", 32'(q_a.size()), 32'd0);
      checkOutput("B queue drained", 32'(q_b.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, failures);
      $finish;
   end

endmodule
